// File: rtl/trap_param_ctrl.sv
// Parameter-bank sequencer for the trapezoidal filter: the host fills a shadow register file,
// and on commit the whole set is streamed into the filter in one burst while the filter is idle.
module trap_param_ctrl #(
  parameter int Nbits      = 14,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PARAMS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [Nbits-1:0]      host_data,
  input  logic                  host_we,
  input  logic                  host_commit,
  output logic                  host_ready,
  input  logic                  filt_busy,
  output logic [ADDR_WIDTH-1:0] selParam,
  output logic [Nbits-1:0]      params,
  output logic                  param_we,
  output logic                  cfg_done,
  output logic                  cfg_loaded,
  output logic                  err
);

  localparam int IW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_P    = (ADDR_WIDTH + 1)'(NUM_PARAMS);
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(NUM_PARAMS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_QUIET, STREAM, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] sel_d;
  logic [Nbits-1:0]      params_d;
  logic                  we_d, done_d, loaded_d, err_d;
  logic [Nbits-1:0]      shadow [NUM_PARAMS];
  logic                  addr_ok;
  logic                  shadow_we;

  assign host_ready = (state_q == IDLE);
  assign addr_ok    = ({1'b0, host_addr} < NUM_P);
  assign shadow_we  = (state_q == IDLE) && host_we && addr_ok;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
    end else if (shadow_we) begin
      shadow[host_addr[IW-1:0]] <= host_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      selParam   <= '0;
      params     <= '0;
      param_we   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      selParam   <= sel_d;
      params     <= params_d;
      param_we   <= we_d;
      cfg_done   <= done_d;
      cfg_loaded <= loaded_d;
      err        <= err_d;
    end
  end

  // A busy filter mid-stream aborts the beat and restarts the whole set from entry 0 later.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sel_d    = selParam;
    params_d = params;
    we_d     = 1'b0;
    done_d   = 1'b0;
    loaded_d = cfg_loaded;
    err_d    = err;
    case (state_q)
      IDLE: begin
        if (host_commit) begin
          state_d  = WAIT_QUIET;
          idx_d    = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end
        if (host_we && !addr_ok) err_d = 1'b1;
      end
      WAIT_QUIET: begin
        if (!filt_busy) state_d = STREAM;
      end
      STREAM: begin
        if (filt_busy) begin
          idx_d   = '0;
          state_d = WAIT_QUIET;
        end else begin
          sel_d    = idx_q[ADDR_WIDTH-1:0];
          params_d = shadow[idx_q[IW-1:0]];
          we_d     = 1'b1;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
